// File: rtl/ysyx_23060203_wbu_if.sv
// Bundle of the WBU's upstream (EXU), data-memory read and GPR write-port signals.
// The slave modport is the WBU's view; master is the surrounding pipeline's view.
interface ysyx_23060203_wbu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        in_is_load;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  logic        busy;
  logic [4:0]  busy_rd;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        err;

  modport slave (
    input  in_valid, in_pc, in_rd, in_data, in_is_load, in_ld_size, in_ld_signed,
    output in_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    output gpr_wen, gpr_waddr, gpr_wdata,
    output busy, busy_rd, retire_valid, retire_pc, err
  );

  modport master (
    output in_valid, in_pc, in_rd, in_data, in_is_load, in_ld_size, in_ld_signed,
    input  in_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
    input  gpr_wen, gpr_waddr, gpr_wdata,
    input  busy, busy_rd, retire_valid, retire_pc, err
  );
endinterface

// File: rtl/ysyx_23060203_wbu.sv
// Writeback stage: retires one instruction at a time, performing the data-memory
// read for loads, and drives the GPR write port for exactly one cycle.
module ysyx_23060203_wbu #(
  parameter int NR_REG = 16
) (
  input logic                 clock,
  input logic                 reset,
  ysyx_23060203_wbu_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MREQ, S_MRESP, S_WB} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  size;
    logic        sgn;
    logic        supp;
  } inst_t;

  state_t      state_q, state_d;
  inst_t       inst_q;
  logic        err_q;
  logic        accept;
  logic        misalign;
  logic        rd_ok;
  logic [31:0] ld_val;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Size 3 behaves as word, so size[1] alone selects the word alignment rule.
  assign misalign = bus.in_is_load &&
                    (((bus.in_ld_size == 2'd1) && bus.in_data[0]) ||
                     (bus.in_ld_size[1] && (bus.in_data[1:0] != 2'b00)));

  assign rd_ok = (inst_q.rd != 5'd0) && ({27'd0, inst_q.rd} < 32'(NR_REG));

  assign lane    = inst_q.data[1:0];
  assign ld_byte = bus.mem_resp_data[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? bus.mem_resp_data[31:16] : bus.mem_resp_data[15:0];

  always_comb begin
    ld_val = bus.mem_resp_data;
    case (inst_q.size)
      2'd0:    ld_val = {{24{inst_q.sgn & ld_byte[7]}}, ld_byte};
      2'd1:    ld_val = {{16{inst_q.sgn & ld_half[15]}}, ld_half};
      default: ld_val = bus.mem_resp_data;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    accept            = 1'b0;
    bus.in_ready      = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.gpr_wen       = 1'b0;
    bus.retire_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = (bus.in_is_load && !misalign) ? S_MREQ : S_WB;
        end
      end
      S_MREQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = S_MRESP;
      end
      S_MRESP: begin
        if (bus.mem_resp_valid) state_d = S_WB;
      end
      S_WB: begin
        bus.retire_valid = 1'b1;
        bus.gpr_wen      = !inst_q.supp && rd_ok;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      inst_q.pc   <= bus.in_pc;
      inst_q.rd   <= bus.in_rd;
      inst_q.data <= bus.in_data;
      inst_q.size <= bus.in_ld_size;
      inst_q.sgn  <= bus.in_ld_signed;
      inst_q.supp <= misalign;
      if (misalign) err_q <= 1'b1;
    end else if ((state_q == S_MRESP) && bus.mem_resp_valid) begin
      // Loaded value replaces the address; a bus error still retires, just unwritten.
      inst_q.data <= ld_val;
      if (bus.mem_resp_err) begin
        inst_q.supp <= 1'b1;
        err_q       <= 1'b1;
      end
    end
  end

  assign bus.mem_req_addr = {inst_q.data[31:2], 2'b00};
  assign bus.gpr_waddr    = inst_q.rd;
  assign bus.gpr_wdata    = inst_q.data;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.busy_rd      = (state_q != S_IDLE) ? inst_q.rd : 5'd0;
  assign bus.retire_pc    = inst_q.pc;
  assign bus.err          = err_q;

endmodule
